// File: rtl/div_flag_sched.sv
// Round-robin clock-enable scheduler: one programmable divider whose ticks are handed out as one-cycle per-channel flags.
// Optional tick-drop statistics are compiled in with `define DIV_SCHED_STAT_EN (adds stat_clr_i / drop_cnt_o).
module div_flag_sched #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int DEF_RATIO = 4,
    localparam int ID_W     = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              cfg_valid_i,
    input  logic [CNT_W-1:0]  cfg_ratio_i,
    output logic              cfg_ready_o,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] po_flag_o,
    output logic [ID_W-1:0]   gnt_id_o,
    output logic              busy_o
`ifdef DIV_SCHED_STAT_EN
    ,
    input  logic              stat_clr_i,
    output logic [15:0]       drop_cnt_o
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   ratio_q;
    logic [CNT_W-1:0]   pend_ratio_q;
    logic               pend_vld_q;
    logic [CNT_W-1:0]   div_cnt_q;
    logic [ID_W-1:0]    ptr_q;
    logic [NUM_CH-1:0]  po_flag_q;
    logic [ID_W-1:0]    gnt_id_q;

    logic [CNT_W-1:0]   ratio_eff;
    logic               tick;
    logic               cfg_fire;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    ptr_d;
    logic [NUM_CH-1:0]  po_flag_d;

    // Ratios 0 and 1 both collapse to a tick every cycle.
    assign ratio_eff   = (ratio_q == '0) ? CNT_W'(1) : ratio_q;
    assign tick        = (state_q == RUN) && en_i && (div_cnt_q == ratio_eff - CNT_W'(1));
    assign cfg_ready_o = ~pend_vld_q;
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;

    always_comb begin
        int idx;
        int nxt;
        idx       = 0;
        nxt       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        po_flag_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr_q) + k) % NUM_CH;
            if (!gnt_found && req_i[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[ID_W-1:0];
            end
        end
        nxt   = (int'(gnt_idx) + 1) % NUM_CH;
        ptr_d = nxt[ID_W-1:0];
        if (tick && gnt_found) begin
            po_flag_d[gnt_idx] = 1'b1;
        end
    end

    // A ratio accepted while running is parked until the next tick so the current period always completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ratio_q      <= CNT_W'(DEF_RATIO);
            pend_ratio_q <= '0;
            pend_vld_q   <= 1'b0;
            div_cnt_q    <= '0;
            ptr_q        <= '0;
            po_flag_q    <= '0;
            gnt_id_q     <= '0;
        end else begin
            po_flag_q <= po_flag_d;
            if (tick && gnt_found) begin
                gnt_id_q <= gnt_idx;
                ptr_q    <= ptr_d;
            end
            case (state_q)
                IDLE: begin
                    div_cnt_q <= '0;
                    if (cfg_fire) begin
                        ratio_q <= cfg_ratio_i;
                    end
                    if (en_i) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state_q    <= IDLE;
                        div_cnt_q  <= '0;
                        pend_vld_q <= 1'b0;
                        if (cfg_fire) begin
                            ratio_q <= cfg_ratio_i;
                        end else if (pend_vld_q) begin
                            ratio_q <= pend_ratio_q;
                        end
                    end else begin
                        if (tick) begin
                            div_cnt_q <= '0;
                            if (pend_vld_q) begin
                                ratio_q    <= pend_ratio_q;
                                pend_vld_q <= 1'b0;
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + CNT_W'(1);
                        end
                        if (cfg_fire) begin
                            pend_ratio_q <= cfg_ratio_i;
                            pend_vld_q   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign po_flag_o = po_flag_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = (state_q == RUN);

`ifdef DIV_SCHED_STAT_EN
    logic [15:0] drop_cnt_q;

    // Counts ticks nobody asked for; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clr_i) begin
            drop_cnt_q <= '0;
        end else if (tick && !gnt_found && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_div_flag_sched.sv
// Directed bench for div_flag_sched: expected grant pulses are queued as each step is driven and matched per cycle.
module tb_div_flag_sched;

    logic       clock;
    logic       reset;
    logic       en;
    logic       cfgValid;
    logic [7:0] cfgRatio;
    logic       cfgReady;
    logic [3:0] req;
    logic [3:0] poFlag;
    logic [1:0] gntId;
    logic       busy;
`ifdef DIV_SCHED_STAT_EN
    logic        statClr;
    logic [15:0] dropCnt;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] flag;
        logic [1:0] id;
    } expect_t;

    expect_t expQ[$];
    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    logic    monEn = 1'b0;
    logic [1:0] expGnt = 2'd0;

    div_flag_sched #(.NUM_CH(4), .CNT_W(8), .DEF_RATIO(4)) dut (
        .clk_i       (clock),
        .rst_i       (reset),
        .en_i        (en),
        .cfg_valid_i (cfgValid),
        .cfg_ratio_i (cfgRatio),
        .cfg_ready_o (cfgReady),
        .req_i       (req),
        .po_flag_o   (poFlag),
        .gnt_id_o    (gntId),
        .busy_o      (busy)
`ifdef DIV_SCHED_STAT_EN
        ,
        .stat_clr_i  (statClr),
        .drop_cnt_o  (dropCnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] r, input logic v, input logic [7:0] ratio);
        en       = e;
        req      = r;
        cfgValid = v;
        cfgRatio = ratio;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expectPulse(input int at, input logic [3:0] flag, input logic [1:0] id);
        expect_t e;
        e.cyc  = at;
        e.flag = flag;
        e.id   = id;
        expQ.push_back(e);
    endtask

    // Outside scheduled grant cycles the flags must be quiet and gnt_id must hold.
    always @(negedge clock) begin
        if (monEn) begin
            if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                checkOutput("po_flag", 32'(poFlag), 32'(expQ[0].flag));
                checkOutput("gnt_id", 32'(gntId), 32'(expQ[0].id));
                expGnt = expQ[0].id;
                void'(expQ.pop_front());
            end else begin
                checkOutput("po_flag_quiet", 32'(poFlag), 32'd0);
                checkOutput("gnt_id_hold", 32'(gntId), 32'(expGnt));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0, c1, c2, c3, c4, c5, c6;
        reset = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 8'd0);
`ifdef DIV_SCHED_STAT_EN
        statClr = 1'b0;
`endif
        waitCycle(3);
        reset = 1'b0;
        checkOutput("reset_po_flag", 32'(poFlag), 32'd0);
        checkOutput("reset_gnt_id", 32'(gntId), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cfg_ready", 32'(cfgReady), 32'd1);
        expGnt = 2'd0;
        monEn  = 1'b1;

        $display("[TB] default ratio, all channels requesting");
        c0 = cyc;
        applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0);
        expectPulse(c0 + 5,  4'b0001, 2'd0);
        expectPulse(c0 + 9,  4'b0010, 2'd1);
        expectPulse(c0 + 13, 4'b0100, 2'd2);
        expectPulse(c0 + 17, 4'b1000, 2'd3);
        expectPulse(c0 + 21, 4'b0001, 2'd0);
        waitCycle(c0 + 21);
        checkOutput("busy_run", 32'(busy), 32'd1);
        waitCycle(c0 + 22);
        applyStimulus(1'b0, 4'b1111, 1'b0, 8'd0);
        waitCycle(c0 + 24);
        checkOutput("busy_idle", 32'(busy), 32'd0);

        $display("[TB] ratio 2, sparse requests, then en drop on a tick");
        c1 = cyc;
        checkOutput("cfg_ready_idle", 32'(cfgReady), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 8'd2);
        waitCycle(c1 + 1);
        applyStimulus(1'b1, 4'b0101, 1'b0, 8'd0);
        expectPulse(c1 + 4,  4'b0100, 2'd2);
        expectPulse(c1 + 6,  4'b0001, 2'd0);
        expectPulse(c1 + 8,  4'b0100, 2'd2);
        expectPulse(c1 + 10, 4'b0001, 2'd0);
        expectPulse(c1 + 12, 4'b0001, 2'd0);
        expectPulse(c1 + 14, 4'b0001, 2'd0);
        expectPulse(c1 + 16, 4'b0001, 2'd0);
        waitCycle(c1 + 10);
        applyStimulus(1'b1, 4'b0001, 1'b0, 8'd0);
        waitCycle(c1 + 17);
        applyStimulus(1'b0, 4'b0001, 1'b0, 8'd0);
        waitCycle(c1 + 18);
        checkOutput("busy_after_drop", 32'(busy), 32'd0);
        c2 = c1 + 19;
        waitCycle(c2);
        applyStimulus(1'b1, 4'b0001, 1'b0, 8'd0);
        expectPulse(c2 + 3, 4'b0001, 2'd0);
        waitCycle(c2 + 3);
        applyStimulus(1'b0, 4'b0001, 1'b0, 8'd0);

        $display("[TB] ratio change while running");
        waitCycle(c2 + 5);
        c3 = cyc;
        applyStimulus(1'b0, 4'b0000, 1'b1, 8'd4);
        waitCycle(c3 + 1);
        applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0);
        expectPulse(c3 + 6,  4'b0010, 2'd1);
        expectPulse(c3 + 10, 4'b0100, 2'd2);
        expectPulse(c3 + 17, 4'b1000, 2'd3);
        expectPulse(c3 + 24, 4'b0001, 2'd0);
        waitCycle(c3 + 6);
        checkOutput("cfg_ready_before", 32'(cfgReady), 32'd1);
        applyStimulus(1'b1, 4'b1111, 1'b1, 8'd7);
        waitCycle(c3 + 7);
        checkOutput("cfg_ready_pending", 32'(cfgReady), 32'd0);
        applyStimulus(1'b1, 4'b1111, 1'b1, 8'd9);
        waitCycle(c3 + 8);
        checkOutput("cfg_ready_still_pending", 32'(cfgReady), 32'd0);
        applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0);
        waitCycle(c3 + 10);
        checkOutput("cfg_ready_applied", 32'(cfgReady), 32'd1);
        waitCycle(c3 + 25);
        applyStimulus(1'b0, 4'b1111, 1'b0, 8'd0);

        $display("[TB] ratio 0 and 1 tick every cycle");
        waitCycle(c3 + 27);
        c4 = cyc;
        applyStimulus(1'b0, 4'b0000, 1'b1, 8'd0);
        waitCycle(c4 + 1);
        applyStimulus(1'b1, 4'b0010, 1'b0, 8'd0);
        for (int k = 3; k <= 8; k++) begin
            expectPulse(c4 + k, 4'b0010, 2'd1);
        end
        waitCycle(c4 + 6);
        applyStimulus(1'b1, 4'b0010, 1'b1, 8'd1);
        waitCycle(c4 + 7);
        applyStimulus(1'b1, 4'b0010, 1'b0, 8'd0);
        checkOutput("cfg_ready_r1_pending", 32'(cfgReady), 32'd0);
        waitCycle(c4 + 8);
        applyStimulus(1'b0, 4'b0010, 1'b0, 8'd0);
        checkOutput("cfg_ready_r1_applied", 32'(cfgReady), 32'd1);

        $display("[TB] reset mid-count with pending ratio");
        waitCycle(c4 + 10);
        c5 = cyc;
        applyStimulus(1'b0, 4'b0000, 1'b1, 8'd6);
        waitCycle(c5 + 1);
        applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0);
        waitCycle(c5 + 3);
        applyStimulus(1'b1, 4'b1111, 1'b1, 8'd3);
        waitCycle(c5 + 4);
        applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0);
        checkOutput("cfg_ready_pre_reset", 32'(cfgReady), 32'd0);
        monEn = 1'b0;
        reset = 1'b1;
        waitCycle(c5 + 5);
        reset = 1'b0;
        applyStimulus(1'b0, 4'b1111, 1'b0, 8'd0);
        checkOutput("rst2_po_flag", 32'(poFlag), 32'd0);
        checkOutput("rst2_gnt_id", 32'(gntId), 32'd0);
        checkOutput("rst2_busy", 32'(busy), 32'd0);
        checkOutput("rst2_cfg_ready", 32'(cfgReady), 32'd1);
        expGnt = 2'd0;
        monEn  = 1'b1;
        waitCycle(c5 + 6);
        applyStimulus(1'b1, 4'b1111, 1'b0, 8'd0);
        expectPulse(c5 + 11, 4'b0001, 2'd0);
        expectPulse(c5 + 15, 4'b0010, 2'd1);
        waitCycle(c5 + 16);
        applyStimulus(1'b0, 4'b1111, 1'b0, 8'd0);

        $display("[TB] ticks with no requests are dropped");
        waitCycle(c5 + 18);
        c6 = cyc;
`ifdef DIV_SCHED_STAT_EN
        checkOutput("drop_cnt_start", 32'(dropCnt), 32'd0);
`endif
        applyStimulus(1'b1, 4'b0000, 1'b0, 8'd0);
        waitCycle(c6 + 6);
        applyStimulus(1'b1, 4'b0001, 1'b0, 8'd0);
        waitCycle(c6 + 7);
        applyStimulus(1'b1, 4'b0000, 1'b0, 8'd0);
        waitCycle(c6 + 13);
        applyStimulus(1'b0, 4'b0000, 1'b0, 8'd0);
`ifdef DIV_SCHED_STAT_EN
        checkOutput("drop_cnt_three", 32'(dropCnt), 32'd3);
        statClr = 1'b1;
        waitCycle(c6 + 14);
        statClr = 1'b0;
        checkOutput("drop_cnt_cleared", 32'(dropCnt), 32'd0);
`endif
        // A request that never overlaps a tick must not leave a late grant behind.
        expectPulse(c6 + 21, 4'b0100, 2'd2);
        waitCycle(c6 + 16);
        applyStimulus(1'b1, 4'b1100, 1'b0, 8'd0);
        waitCycle(c6 + 21);
        applyStimulus(1'b0, 4'b0000, 1'b0, 8'd0);

        waitCycle(c6 + 24);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        monEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
